// File: rtl/t01_ai_score_eval_if.sv
// Feature-extract handshake between the AI score evaluator (master) and the
// board feature extractor (slave).
interface t01_ai_score_eval_if;
  logic       extract_start;
  logic       extract_ready;
  logic       ofm_done;
  logic [7:0] lines_cleared;
  logic [7:0] holes;
  logic [7:0] bumpiness;
  logic [7:0] height_sum;

  modport master (
    output extract_start, ofm_done,
    input  extract_ready, lines_cleared, holes, bumpiness, height_sum
  );

  modport slave (
    input  extract_start, ofm_done,
    output extract_ready, lines_cleared, holes, bumpiness, height_sum
  );
endinterface

// File: rtl/t01_ai_score_eval.sv
// AI candidate scorer: fetches board features, serially accumulates a signed
// weighted score and tracks the best candidate of a batch. Optional macro:
// T01_AI_SCORE_TETRIS_BONUS_EN adds TETRIS_BONUS when four lines are cleared.
module t01_ai_score_eval #(
  parameter logic [7:0] W_LINES  = 8'd76,
  parameter logic [7:0] W_HOLES  = 8'd36,
  parameter logic [7:0] W_BUMP   = 8'd18,
  parameter logic [7:0] W_HEIGHT = 8'd51
`ifdef T01_AI_SCORE_TETRIS_BONUS_EN
  , parameter logic [9:0] TETRIS_BONUS = 10'd200
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      eval_start,
  input  logic [5:0]                candidate_id,
  input  logic                      candidate_first,
  input  logic                      candidate_last,
  t01_ai_score_eval_if.master       ext,
  output logic                      eval_busy,
  output logic                      eval_done,
  output logic signed [19:0]        last_score,
  output logic signed [19:0]        best_score,
  output logic [5:0]                best_id,
  output logic                      best_valid
);

  typedef enum logic [2:0] {IDLE, REQ, ACK, MAC, CMP, DONE} state_t;

  state_t             state, state_nx;
  logic [5:0]         tag;
  logic               first_q, last_q;
  logic [7:0]         f_lines, f_holes, f_bump, f_height;
  logic [1:0]         term;
  logic signed [19:0] acc;
  logic signed [19:0] score;
  logic [7:0]         mul_w, mul_f;
  logic [15:0]        product;
  logic signed [19:0] term_val;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Outputs decode from the registered state, so reset drops them on the
  // very edge that returns the FSM to IDLE.
  // NOTE: every output of a combinational block gets a default first; a
  // missed branch would otherwise infer a latch.
  always_comb begin
    state_nx          = state;
    ext.extract_start = 1'b0;
    ext.ofm_done      = 1'b0;
    eval_busy         = 1'b1;
    eval_done         = 1'b0;
    best_valid        = 1'b0;
    unique case (state)
      IDLE: begin
        eval_busy = 1'b0;
        if (eval_start) state_nx = REQ;
      end
      REQ: begin
        ext.extract_start = 1'b1;
        if (ext.extract_ready) state_nx = ACK;
      end
      ACK: begin
        // Extractor only advances while its start is high, so hold it here.
        ext.extract_start = 1'b1;
        ext.ofm_done      = 1'b1;
        state_nx          = MAC;
      end
      MAC:  if (term == 2'd3) state_nx = CMP;
      CMP:  state_nx = DONE;
      DONE: begin
        eval_done  = 1'b1;
        best_valid = last_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One weight/feature pair per MAC cycle; term 0 is the only reward.
  always_comb begin
    mul_w = W_LINES;
    mul_f = f_lines;
    unique case (term)
      2'd1:    begin mul_w = W_HOLES;  mul_f = f_holes;  end
      2'd2:    begin mul_w = W_BUMP;   mul_f = f_bump;   end
      2'd3:    begin mul_w = W_HEIGHT; mul_f = f_height; end
      default: begin mul_w = W_LINES;  mul_f = f_lines;  end
    endcase
  end

  assign product  = {8'd0, mul_w} * {8'd0, mul_f};
  assign term_val = signed'({4'd0, product});

`ifdef T01_AI_SCORE_TETRIS_BONUS_EN
  assign score = (f_lines == 8'd4) ? acc + signed'({10'd0, TETRIS_BONUS}) : acc;
`else
  assign score = acc;
`endif

  // NOTE: all datapath registers are reset (no memories here), so every
  // output, including the best-score record, reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag        <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      f_lines    <= '0;
      f_holes    <= '0;
      f_bump     <= '0;
      f_height   <= '0;
      term       <= '0;
      acc        <= '0;
      last_score <= '0;
      best_score <= '0;
      best_id    <= '0;
    end else begin
      if (state == IDLE && eval_start) begin
        tag     <= candidate_id;
        first_q <= candidate_first;
        last_q  <= candidate_last;
      end
      if (state == REQ && ext.extract_ready) begin
        f_lines  <= ext.lines_cleared;
        f_holes  <= ext.holes;
        f_bump   <= ext.bumpiness;
        f_height <= ext.height_sum;
      end
      if (state == ACK) begin
        acc  <= '0;
        term <= '0;
      end
      if (state == MAC) begin
        acc  <= (term == 2'd0) ? acc + term_val : acc - term_val;
        term <= term + 2'd1;
      end
      if (state == CMP) begin
        last_score <= score;
        // Strict compare: ties keep the earlier candidate.
        if (first_q || score > best_score) begin
          best_score <= score;
          best_id    <= tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_t01_ai_score_eval.sv
// Self-checking bench for t01_ai_score_eval: a spec-level score/best model
// checked every cycle, plus literal expectations from the worked examples.
`timescale 1ns/1ps
module tb_t01_ai_score_eval;

  logic               clk = 1'b0;
  logic               rst;
  logic               eval_start;
  logic [5:0]         candidate_id;
  logic               candidate_first;
  logic               candidate_last;
  logic               eval_busy;
  logic               eval_done;
  logic signed [19:0] last_score;
  logic signed [19:0] best_score;
  logic [5:0]         best_id;
  logic               best_valid;

  t01_ai_score_eval_if ext_if ();

  t01_ai_score_eval dut (
    .clk             (clk),
    .rst             (rst),
    .eval_start      (eval_start),
    .candidate_id    (candidate_id),
    .candidate_first (candidate_first),
    .candidate_last  (candidate_last),
    .ext             (ext_if),
    .eval_busy       (eval_busy),
    .eval_done       (eval_done),
    .last_score      (last_score),
    .best_score      (best_score),
    .best_id         (best_id),
    .best_valid      (best_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs for the current cycle.
  bit exp_es, exp_ofm, exp_busy, exp_done, exp_bv;
  int exp_last, exp_best, exp_id;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Score straight from the weighting rules.
  function automatic int model_score(input int l, input int h, input int b, input int s);
    int sc;
    sc = 76 * l - 36 * h - 18 * b - 51 * s;
`ifdef T01_AI_SCORE_TETRIS_BONUS_EN
    if (l == 4) sc += 200;
`endif
    return sc;
  endfunction

  task automatic set_idle_exp();
    exp_es = 0; exp_ofm = 0; exp_busy = 0; exp_done = 0; exp_bv = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One candidate. Cycle 0 carries eval_start; extract_ready is high only in
  // cycle k. Optional stray eval_start at cycle stray_at, reset at rst_at.
  task automatic run_cand(input logic [5:0] id, input bit first, input bit last,
                          input int l, input int h, input int b, input int s,
                          input int k, input int stray_at, input int rst_at);
    int sc;
    for (int c = 0; c <= k + 7; c++) begin
      eval_start      = (c == 0) || (c == stray_at);
      candidate_id    = (c == 0) ? id : 6'd63;
      candidate_first = (c == 0) ? first : ~first;
      candidate_last  = (c == 0) ? last : ~last;
      rst             = (c == rst_at);
      ext_if.extract_ready = (c == k);
      ext_if.lines_cleared = (c == k) ? 8'(l) : 8'(c * 13 + 7);
      ext_if.holes         = (c == k) ? 8'(h) : 8'(c * 29 + 3);
      ext_if.bumpiness     = (c == k) ? 8'(b) : 8'(c * 5 + 11);
      ext_if.height_sum    = (c == k) ? 8'(s) : 8'(c * 17 + 1);

      exp_es   = (c >= 1) && (c <= k + 1);
      exp_ofm  = (c == k + 1);
      exp_busy = (c >= 1);
      exp_done = (c == k + 7);
      exp_bv   = (c == k + 7) && last;
      if (c == k + 7) begin
        sc       = model_score(l, h, b, s);
        exp_last = sc;
        if (first || sc > exp_best) begin
          exp_best = sc;
          exp_id   = int'(id);
        end
      end
      next_cycle();

      if (c == rst_at) begin
        rst = 1'b0;
        eval_start = 1'b0;
        ext_if.extract_ready = 1'b0;
        set_idle_exp();
        exp_last = 0; exp_best = 0; exp_id = 0;
        check("rst_extract_start", int'(ext_if.extract_start), 0);
        check("rst_ofm_done", int'(ext_if.ofm_done), 0);
        check("rst_eval_busy", int'(eval_busy), 0);
        check("rst_best_score", int'(best_score), 0);
        check("rst_last_score", int'(last_score), 0);
        return;
      end
    end
    eval_start = 1'b0;
    ext_if.extract_ready = 1'b0;
    set_idle_exp();
  endtask

  initial begin
    rst = 1'b1;
    eval_start = 1'b0;
    candidate_id = '0;
    candidate_first = 1'b0;
    candidate_last = 1'b0;
    ext_if.extract_ready = 1'b0;
    ext_if.lines_cleared = '0;
    ext_if.holes = '0;
    ext_if.bumpiness = '0;
    ext_if.height_sum = '0;
    set_idle_exp();
    exp_last = 0; exp_best = 0; exp_id = 0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          check("extract_start", int'(ext_if.extract_start), int'(exp_es));
          check("ofm_done", int'(ext_if.ofm_done), int'(exp_ofm));
          check("eval_busy", int'(eval_busy), int'(exp_busy));
          check("eval_done", int'(eval_done), int'(exp_done));
          check("best_valid", int'(best_valid), int'(exp_bv));
          check("last_score", int'(last_score), exp_last);
          check("best_score", int'(best_score), exp_best);
          check("best_id", int'(best_id), exp_id);
        end
      end
    join_none

    next_cycle();
    chk_en = 1'b1;
    check("reset_best_score", int'(best_score), 0);
    check("reset_best_id", int'(best_id), 0);
    check("reset_eval_done", int'(eval_done), 0);
    next_cycle();
    rst = 1'b0;

    // Worked example: ready at cycle 3, done at cycle 10, score -560.
    run_cand(6'd1, 1, 1, 1, 2, 3, 10, 3, -1, -1);
    check("ex1_last_score", int'(last_score), -560);
    check("ex1_best_score", int'(best_score), -560);

    // Batch of three; the tie at -200 keeps id 9.
    run_cand(6'd5,  1, 0, 1, 2, 3, 10, 1, -1, -1);
    run_cand(6'd9,  0, 0, 1, 2, 0, 4,  2, -1, -1);
    run_cand(6'd12, 0, 1, 1, 2, 0, 4,  4, -1, -1);
    check("batch_best_id", int'(best_id), 9);
    check("batch_best_score", int'(best_score), -200);
    check("batch_last_score", int'(last_score), -200);

    // Extremes: largest penalty, and four cleared lines.
    run_cand(6'd20, 1, 1, 0, 255, 255, 255, 2, -1, -1);
    check("extreme_neg", int'(last_score), -26775);
    run_cand(6'd21, 1, 1, 4, 0, 0, 0, 1, -1, -1);
`ifdef T01_AI_SCORE_TETRIS_BONUS_EN
    check("four_lines", int'(last_score), 504);
`else
    check("four_lines", int'(last_score), 304);
`endif

    // Extractor stalls 50 cycles; a stray eval_start during the wait is ignored.
    run_cand(6'd33, 1, 1, 2, 1, 1, 1, 51, 20, -1);
    check("stall_best_id", int'(best_id), 33);
    check("stall_score", int'(last_score), 47);

    // Reset during MAC, then a fresh first candidate overwrites best.
    run_cand(6'd40, 1, 1, 3, 0, 0, 0, 2, -1, 5);
    run_cand(6'd41, 1, 1, 0, 1, 0, 0, 1, -1, -1);
    check("post_rst_best_id", int'(best_id), 41);
    check("post_rst_best_score", int'(best_score), -36);

    next_cycle();
    next_cycle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
